// File: rtl/morse_decoder.sv
// Morse symbol-to-ASCII decoder: collects dots/dashes, emits a character after a letter gap.
// Define MORSE_WORD_GAP_EN to add WORD_WAIT, which emits a space (0x20) after a word gap.
module morse_decoder #(
  parameter int unsigned GAP_CYCLES      = 12_500_000,
  parameter int unsigned WORD_GAP_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic       sym_long,
  input  logic       char_ready,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       char_err,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1
`ifdef MORSE_WORD_GAP_EN
    , WORD_WAIT = 2'd2
`endif
  } state_t;

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [31:0] WORD_LAST = 32'(WORD_GAP_CYCLES - 1);
`endif

  if (GAP_CYCLES == 0 || WORD_GAP_CYCLES <= GAP_CYCLES) begin : g_param_check
    $error("morse_decoder: requires 0 < GAP_CYCLES < WORD_GAP_CYCLES");
  end

  state_t      state, state_next;
  logic [2:0]  count;
  logic [4:0]  shreg;
  logic [31:0] gap_cnt;
  logic        emit, letter_end, emit_err;
  logic [7:0]  emit_code, decoded;

  // Patterns are right-aligned; the first symbol sits in bit cnt-1, 1 = dash.
  function automatic logic [7:0] decode(input logic [2:0] cnt, input logic [4:0] pat);
    logic [7:0] c;
    c = 8'h3F;
    case (cnt)
      3'd1: c = pat[0] ? "T" : "E";
      3'd2:
        case (pat[1:0])
          2'b00: c = "I";  2'b01: c = "A";  2'b10: c = "N";  2'b11: c = "M";
          default: c = 8'h3F;
        endcase
      3'd3:
        case (pat[2:0])
          3'b000: c = "S";  3'b001: c = "U";  3'b010: c = "R";  3'b011: c = "W";
          3'b100: c = "D";  3'b101: c = "K";  3'b110: c = "G";  3'b111: c = "O";
          default: c = 8'h3F;
        endcase
      3'd4:
        case (pat[3:0])
          4'b0000: c = "H";  4'b0001: c = "V";  4'b0010: c = "F";  4'b0100: c = "L";
          4'b0110: c = "P";  4'b0111: c = "J";  4'b1000: c = "B";  4'b1001: c = "X";
          4'b1010: c = "C";  4'b1011: c = "Y";  4'b1100: c = "Z";  4'b1101: c = "Q";
          default: c = 8'h3F;
        endcase
      3'd5:
        case (pat)
          5'b11111: c = "0";  5'b01111: c = "1";  5'b00111: c = "2";  5'b00011: c = "3";
          5'b00001: c = "4";  5'b00000: c = "5";  5'b10000: c = "6";  5'b11000: c = "7";
          5'b11100: c = "8";  5'b11110: c = "9";
          default:  c = 8'h3F;
        endcase
      default: c = 8'h3F;
    endcase
    return c;
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    letter_end = 1'b0;
    emit_code  = 8'h00;
    emit_err   = 1'b0;
    decoded    = decode(count, shreg);
    case (state)
      IDLE: if (sym_valid) state_next = COLLECT;
      COLLECT: begin
        // A symbol arriving on the expiry cycle wins over the letter end.
        if (!sym_valid && gap_cnt == GAP_LAST) begin
          emit       = 1'b1;
          letter_end = 1'b1;
          emit_code  = decoded;
          emit_err   = (decoded == 8'h3F);
`ifdef MORSE_WORD_GAP_EN
          state_next = WORD_WAIT;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef MORSE_WORD_GAP_EN
      WORD_WAIT: begin
        if (sym_valid) begin
          state_next = COLLECT;
        end else if (gap_cnt == WORD_LAST) begin
          emit       = 1'b1;
          emit_code  = 8'h20;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 3'd0;
      shreg   <= 5'd0;
      gap_cnt <= 32'd0;
    end else begin
      state <= state_next;
      if (sym_valid) begin
        shreg   <= {shreg[3:0], sym_long};
        count   <= (count == 3'd6) ? 3'd6 : count + 3'd1;
        gap_cnt <= 32'd0;
      end else begin
        if (letter_end) begin
          shreg <= 5'd0;
          count <= 3'd0;
        end
        if (state_next == IDLE)       gap_cnt <= 32'd0;
        else if (gap_cnt != '1)       gap_cnt <= gap_cnt + 32'd1;
      end
    end
  end

  // Output register: a new char is dropped only if the pending one is not taken this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_valid <= 1'b0;
      char_code  <= 8'h00;
      char_err   <= 1'b0;
      ovf        <= 1'b0;
    end else if (emit) begin
      if (char_valid && !char_ready) begin
        ovf <= 1'b1;
      end else begin
        char_valid <= 1'b1;
        char_code  <= emit_code;
        char_err   <= emit_err;
      end
    end else if (char_valid && char_ready) begin
      char_valid <= 1'b0;
    end
  end

endmodule
